// File: rtl/lsu_mem_responder.sv
// Serializes U/V-pipe loads/stores onto one single-port sync data memory: ack 1 cycle after issue, serialized V 2 cycles, 1-cycle upstream stall on dual request.
// Build option MISALIGN_TRAP_EN: misaligned H/W accesses trap via o_misalign instead of being force-aligned.

package lsu_mem_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_ALU
  } mem_op_e;

  typedef struct packed {
    logic        valid;
    mem_op_e     op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        is_instr2;
  } mem_req_t;

  typedef struct packed {
    logic        valid;
    logic        wren;
    logic [3:0]  bytemask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } mem_ack_t;
endpackage

module lsu_mem_responder
  import lsu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter logic        MEM_SEL = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  mem_req_t          i_req_u,
  input  mem_req_t          i_req_v,
  input  logic              i_flush,
  output logic              o_stall,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [31:0]       o_dmem_wdata,
  output logic [3:0]        o_dmem_bytemask,
  output logic              o_dmem_wren,
  output logic              o_dmem_en,
  input  logic [31:0]       i_dmem_rdata,
  output mem_ack_t          o_ack,
  output logic [4:0]        o_wb_rd,
  output logic              o_wb_wren,
  output logic              o_wb_is_instr2
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              o_misalign
`endif
);

  typedef enum logic {S_IDLE, S_SER2} state_e;

  typedef struct packed {
    logic        valid;
    logic        load;
    logic        store;
    logic        sext;
    logic        is_b;
    logic        is_h;
    logic        misalign;
    logic        slot2;
    logic [1:0]  lane;
    logic [3:0]  mask;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } resp_t;

  state_e   state_q, state_d;
  mem_req_t buf_q, buf_d;
  resp_t    resp_q, resp_d;

  mem_req_t    issue;
  logic        issue_slot2, issue_vld;
  logic        is_store, is_b, is_h, is_w, sext, misalign, dmem_en;
  logic [1:0]  lane_raw, lane;
  logic [3:0]  mask;
  logic [31:0] lane_wdata;
  logic [31:0] rd_shift, rdata_ext;
  logic        ack_ok;

  function automatic logic is_mem(input mem_req_t r);
    return r.valid && (r.op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW});
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      resp_q  <= resp_d;
    end
  end

  // Flush (and reset) wins over everything, including a fresh dual request.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    o_stall     = 1'b0;
    issue       = '0;
    issue_slot2 = 1'b0;
    if (i_rst || i_flush) begin
      state_d = S_IDLE;
      buf_d   = '0;
    end else if (state_q == S_SER2) begin
      issue       = buf_q;
      issue_slot2 = 1'b1;
      buf_d       = '0;
      state_d     = S_IDLE;
    end else if (is_mem(i_req_u)) begin
      issue = i_req_u;
      if (is_mem(i_req_v)) begin
        buf_d   = i_req_v;
        o_stall = 1'b1;
        state_d = S_SER2;
      end
    end else if (is_mem(i_req_v)) begin
      issue       = i_req_v;
      issue_slot2 = 1'b1;
    end
  end

  always_comb begin
    issue_vld = is_mem(issue);
    is_b      = issue.op inside {OP_LB, OP_LBU, OP_SB};
    is_h      = issue.op inside {OP_LH, OP_LHU, OP_SH};
    is_w      = !is_b && !is_h;
    is_store  = issue_vld && (issue.op inside {OP_SB, OP_SH, OP_SW});
    sext      = issue.op inside {OP_LB, OP_LH};
    lane_raw  = issue.addr[1:0];
    misalign  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    lane     = lane_raw;
    misalign = issue_vld && ((is_h && lane_raw[0]) || (is_w && (lane_raw != 2'b00)));
`else
    lane = is_w ? 2'b00 : (is_h ? {lane_raw[1], 1'b0} : lane_raw);
`endif
    if (is_b) begin
      mask       = 4'b0001 << lane;
      lane_wdata = {4{issue.data[7:0]}};
    end else if (is_h) begin
      mask       = 4'b0011 << lane;
      lane_wdata = {2{issue.data[15:0]}};
    end else begin
      mask       = 4'b1111;
      lane_wdata = issue.data;
    end
    dmem_en = issue_vld && !misalign;
  end

  assign o_dmem_en       = dmem_en;
  assign o_dmem_wren     = dmem_en && is_store;
  assign o_dmem_bytemask = dmem_en ? mask : 4'b0000;
  assign o_dmem_wdata    = (dmem_en && is_store) ? lane_wdata : 32'd0;
  assign o_dmem_addr     = dmem_en ? {issue.addr[ADDR_W-1] ^ MEM_SEL, issue.addr[ADDR_W-2:2], 2'b00}
                                   : '0;

  always_comb begin
    resp_d = '0;
    if (issue_vld) begin
      resp_d.valid    = 1'b1;
      resp_d.load     = !is_store;
      resp_d.store    = is_store;
      resp_d.sext     = sext;
      resp_d.is_b     = is_b;
      resp_d.is_h     = is_h;
      resp_d.misalign = misalign;
      resp_d.slot2    = issue_slot2;
      resp_d.lane     = lane;
      resp_d.mask     = misalign ? 4'b0000 : mask;
      resp_d.rd       = issue.rd;
      resp_d.addr     = {issue.addr[31:2], lane};
      resp_d.wdata    = is_store ? lane_wdata : 32'd0;
    end
  end

  // Read data arrives the cycle after issue, so lane select uses the registered lane.
  always_comb begin
    rd_shift = i_dmem_rdata >> {resp_q.lane, 3'b000};
    if (resp_q.is_b)
      rdata_ext = resp_q.sext ? {{24{rd_shift[7]}}, rd_shift[7:0]} : {24'd0, rd_shift[7:0]};
    else if (resp_q.is_h)
      rdata_ext = resp_q.sext ? {{16{rd_shift[15]}}, rd_shift[15:0]} : {16'd0, rd_shift[15:0]};
    else
      rdata_ext = i_dmem_rdata;
    ack_ok           = resp_q.valid && !resp_q.misalign;
    o_ack.valid      = resp_q.valid;
    o_ack.wren       = ack_ok && resp_q.store;
    o_ack.bytemask   = resp_q.mask;
    o_ack.addr       = resp_q.addr;
    o_ack.wdata      = resp_q.wdata;
    o_ack.rdata      = (ack_ok && resp_q.load) ? rdata_ext : 32'd0;
    o_wb_rd          = resp_q.rd;
    o_wb_wren        = ack_ok && resp_q.load && (resp_q.rd != 5'd0);
    o_wb_is_instr2   = resp_q.slot2;
  end

`ifdef MISALIGN_TRAP_EN
  assign o_misalign = resp_q.valid && resp_q.misalign;
`endif

  // Origin slot is tracked by issue position, so the request's own tag bit is redundant.
  logic unused_bits;
  assign unused_bits = issue.is_instr2;

endmodule
